div_issue: RTL and testbench

- Requester-side controller for the multicycle divider: accepts DIV/DIVU from the EX stage, drives the divider's start/annul/operand interface and stalls the pipeline until the result returns.
- Writes the quotient/remainder into the HI/LO write port.
- Handles pipeline flush (annul), returns the divider to idle between operations, and guards against a hung divider with a timeout.

---
 rtl/div_issue.sv | 174 +++++++++++++++++
 tb/tb_div_issue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue.sv
// Requester-side controller for the multicycle divider: issues DIV/DIVU from EX,
// holds the pipeline while the divider works, and writes the result to HI/LO.
module div_issue #(
  parameter int TIMEOUT      = 40,
  parameter int ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        flush,
  output logic        stall_req,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_timeout
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int ACW = $clog2(ABORT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WCW-1:0]   wait_cnt_r;
  logic [WCW-1:0]   wait_cnt_nxt_s;
  logic [ACW-1:0]   abort_cnt_r;
  logic [ACW-1:0]   abort_cnt_nxt_s;
  logic             rst_abort_r;
  logic             rst_abort_nxt_s;
  logic             start_nxt_s;
  logic             annul_nxt_s;
  logic             signed_nxt_s;
  logic [31:0]      op1_nxt_s;
  logic [31:0]      op2_nxt_s;
  logic             we_nxt_s;
  logic [31:0]      hi_nxt_s;
  logic [31:0]      lo_nxt_s;
  logic             tmo_nxt_s;
  logic             req_ok_s;

  assign req_ok_s = ex_div_req & ~flush;

  // Next-state, next register values and the combinational stall request.
  always_comb begin
    state_nxt_s     = state_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    abort_cnt_nxt_s = abort_cnt_r;
    rst_abort_nxt_s = rst_abort_r;
    start_nxt_s     = div_start;
    annul_nxt_s     = 1'b0;
    signed_nxt_s    = div_signed;
    op1_nxt_s       = div_op1;
    op2_nxt_s       = div_op2;
    we_nxt_s        = 1'b0;
    hi_nxt_s        = hi_o;
    lo_nxt_s        = lo_o;
    tmo_nxt_s       = 1'b0;
    stall_req       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_req = req_ok_s;
        if (rst_abort_r) begin
          // A reset may have cut the divider off mid-operation: give it the
          // same quiet period as an abort, but without an annul.
          rst_abort_nxt_s = 1'b0;
          abort_cnt_nxt_s = {ACW{1'b0}};
          start_nxt_s     = 1'b0;
          state_nxt_s     = ST_ABORT;
        end else if (req_ok_s) begin
          op1_nxt_s      = ex_op1;
          op2_nxt_s      = ex_op2;
          signed_nxt_s   = ex_div_signed;
          start_nxt_s    = 1'b1;
          wait_cnt_nxt_s = {WCW{1'b0}};
          state_nxt_s    = ST_BUSY;
        end else begin
          start_nxt_s = 1'b0;
        end
      end
      ST_BUSY: begin
        stall_req = 1'b1;
        if (flush) begin
          start_nxt_s     = 1'b0;
          annul_nxt_s     = 1'b1;
          abort_cnt_nxt_s = {ACW{1'b0}};
          state_nxt_s     = ST_ABORT;
        end else if (div_ready) begin
          hi_nxt_s    = div_result[63:32];
          lo_nxt_s    = div_result[31:0];
          we_nxt_s    = 1'b1;
          start_nxt_s = 1'b0;
          state_nxt_s = ST_DONE;
        end else if (wait_cnt_r == WCW'(TIMEOUT - 1)) begin
          tmo_nxt_s       = 1'b1;
          annul_nxt_s     = 1'b1;
          start_nxt_s     = 1'b0;
          abort_cnt_nxt_s = {ACW{1'b0}};
          state_nxt_s     = ST_ABORT;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
        end
      end
      ST_DONE: begin
        // hilo_we is high in this cycle; the retiring instruction still shows
        // ex_div_req, so the request is deliberately not looked at here.
        start_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      ST_ABORT: begin
        stall_req   = req_ok_s;
        start_nxt_s = 1'b0;
        if (abort_cnt_r == ACW'(ABORT_CYCLES - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          abort_cnt_nxt_s = abort_cnt_r + ACW'(1);
        end
      end
      default: begin
        start_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and all registered divider/HI-LO outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {WCW{1'b0}};
      abort_cnt_r <= {ACW{1'b0}};
      rst_abort_r <= 1'b1;
      div_start   <= 1'b0;
      div_annul   <= 1'b0;
      div_signed  <= 1'b0;
      div_op1     <= 32'd0;
      div_op2     <= 32'd0;
      hilo_we     <= 1'b0;
      hi_o        <= 32'd0;
      lo_o        <= 32'd0;
      div_timeout <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      abort_cnt_r <= abort_cnt_nxt_s;
      rst_abort_r <= rst_abort_nxt_s;
      div_start   <= start_nxt_s;
      div_annul   <= annul_nxt_s;
      div_signed  <= signed_nxt_s;
      div_op1     <= op1_nxt_s;
      div_op2     <= op2_nxt_s;
      hilo_we     <= we_nxt_s;
      hi_o        <= hi_nxt_s;
      lo_o        <= lo_nxt_s;
      div_timeout <= tmo_nxt_s;
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural divider of programmable
// latency (or one that never answers).
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_req;
  logic        ex_div_signed;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        flush;
  logic        stall_req;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_timeout;

  int err_cnt = 0;
  int chk_cnt = 0;
  int we_cnt  = 0;
  int tmo_cnt = 0;

  int   model_lat  = 35;
  logic model_hang = 1'b0;
  int   mcnt;

  div_issue #(.TIMEOUT(40), .ABORT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush), .stall_req(stall_req),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result),
    .div_ready(div_ready), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
    .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Divider model: answers model_lat cycles after start, holds the answer until start drops.
  always @(posedge clk) begin
    if (!div_start) begin
      mcnt       <= 0;
      div_ready  <= 1'b0;
      div_result <= 64'd0;
    end else if (!div_ready) begin
      mcnt <= mcnt + 1;
      if (!model_hang && mcnt == model_lat - 1) begin
        div_ready  <= 1'b1;
        div_result <= model_div(div_op1, div_op2, div_signed);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hilo_we) we_cnt <= we_cnt + 1;
      if (div_timeout) tmo_cnt <= tmo_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide from the current IDLE cycle and waits for the DONE cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_stall);
    int   stall_n = 0;
    logic done    = 1'b0;
    logic bad_op  = 1'b0;
    model_lat = lat;
    ex_op1 = a; ex_op2 = b; ex_div_signed = s; ex_div_req = 1'b1;
    #1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (hilo_we) begin
        done = 1'b1;
      end else begin
        if (stall_req) stall_n++;
        if (div_start && (div_op1 !== a || div_op2 !== b || div_signed !== s)) bad_op = 1'b1;
        tick();
      end
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_stall_done"}, stall_req, 1'b0);
    chk({tag, "_stall_cycles"}, stall_n, exp_stall);
    chk({tag, "_ops_stable"}, bad_op, 1'b0);
  endtask

  initial begin
    int   n;
    logic seen;
    logic start_hi;
    rst = 1'b1; ex_div_req = 1'b0; ex_div_signed = 1'b0;
    ex_op1 = 32'd0; ex_op2 = 32'd0; flush = 1'b0;
    tick(); tick(); tick();
    chk("rst_start", div_start, 1'b0);
    chk("rst_annul", div_annul, 1'b0);
    chk("rst_we", hilo_we, 1'b0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ops", {div_op1, div_op2}, 64'd0);
    chk("rst_tmo", {div_timeout, div_signed}, 2'b00);
    rst = 1'b0;
    tick(); tick(); tick(); tick();

    // 100/7 unsigned, 35-cycle divider: 1 IDLE + 36 BUSY stall cycles
    run_div("u100_7", 32'd100, 32'd7, 1'b0, 35, 32'd2, 32'd14, 37);
    ex_div_req = 1'b0;
    tick();
    chk("u100_7_we_pulse", hilo_we, 1'b0);

    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 12);
    chk("s_m7_2_signed_held", div_signed, 1'b1);
    ex_div_req = 1'b0;
    tick();

    run_div("dz5_0", 32'd5, 32'd0, 1'b0, 8, 32'd0, 32'd0, 10);
    ex_div_req = 1'b0;
    tick();
    chk("dz_no_tmo", tmo_cnt, 0);
    chk("dz_free", {div_start, div_ready}, 2'b00);

    // Flush in BUSY cycle 10
    model_lat = 35;
    ex_op1 = 32'd50; ex_op2 = 32'd5; ex_div_signed = 1'b0; ex_div_req = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    chk("fl_stall_busy", {stall_req, div_start}, 2'b11);
    tick();
    flush = 1'b0; ex_div_req = 1'b0;
    chk("fl_annul1", {div_annul, div_start, hilo_we}, 3'b100);
    tick();
    chk("fl_annul2", {div_annul, div_start}, 2'b00);
    tick();
    chk("fl_start_low", div_start, 1'b0);
    chk("fl_no_we", we_cnt, 3);
    run_div("fl_9_3", 32'd9, 32'd3, 1'b0, 5, 32'd0, 32'd3, 7);
    ex_div_req = 1'b0;
    tick();

    // Divider that never answers: 1 IDLE + 40 BUSY cycles, then timeout
    model_hang = 1'b1;
    ex_op1 = 32'd77; ex_op2 = 32'd7; ex_div_signed = 1'b0; ex_div_req = 1'b1;
    #1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (div_timeout) seen = 1'b1;
      else begin
        if (stall_req) n++;
        tick();
      end
    end
    chk("to_seen", seen, 1'b1);
    chk("to_stall_cycles", n, 41);
    chk("to_annul", {div_annul, div_start}, 2'b10);
    ex_div_req = 1'b0;
    #1;
    chk("to_stall_drop", stall_req, 1'b0);
    model_hang = 1'b0;
    tick();
    chk("to_pulse", {div_timeout, div_annul}, 2'b00);
    tick();
    run_div("to_next", 32'd100, 32'd7, 1'b0, 3, 32'd2, 32'd14, 5);
    chk("to_count", tmo_cnt, 1);

    // Back-to-back: second request is already present in the DONE cycle
    ex_div_req = 1'b0;
    tick();
    run_div("b2b_1", 32'd20, 32'd6, 1'b0, 4, 32'd2, 32'd3, 6);
    ex_op1 = 32'hFFFF_FFFF; ex_op2 = 32'd16;
    tick();
    chk("b2b_idle", {div_start, stall_req}, 2'b01);
    run_div("b2b_2", 32'hFFFF_FFFF, 32'd16, 1'b0, 4, 32'd15, 32'h0FFF_FFFF, 6);
    ex_div_req = 1'b0;
    tick();

    // Reset in the middle of BUSY
    model_lat = 35;
    ex_op1 = 32'd123; ex_op2 = 32'd4; ex_div_signed = 1'b1; ex_div_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("mr_busy", div_start, 1'b1);
    rst = 1'b1; ex_div_req = 1'b0;
    tick();
    chk("mr_clear", {div_start, div_annul, hilo_we, div_timeout, div_signed}, 5'd0);
    chk("mr_clear_data", {div_op1, div_op2, hi_o, lo_o}, 128'd0);
    rst = 1'b0;
    ex_op1 = 32'd9; ex_op2 = 32'd3; ex_div_signed = 1'b0; ex_div_req = 1'b1;
    start_hi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (div_start || div_annul) start_hi = 1'b1;
    end
    chk("mr_quiet", start_hi, 1'b0);
    run_div("mr_9_3", 32'd9, 32'd3, 1'b0, 6, 32'd0, 32'd3, 8);
    ex_div_req = 1'b0;
    tick();
    chk("we_total", we_cnt, 8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
